ar_channel: RTL and testbench
=============================

AR_CHANNEL -- requirements
Module: ar_channel

Interface
- REQ-001 Parameter ADDR_WIDTH, default 32: width of ARADDR and MADDR.
- REQ-002 Parameter DATA_WIDTH, default 32: data bus width; sets the alignment granule (DATA_WIDTH/8 bytes).
- REQ-003 Parameter ADDR_LIMIT, default 32'h0000_1000: first illegal byte address.
- REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
- REQ-005 Port reset, input, 1: synchronous, active-high reset.
- REQ-006 Port ARVALID, input, 1: master read address valid.
- REQ-007 Port ARREADY, output, 1: slave can accept an address.
- REQ-008 Port ARADDR, input, ADDR_WIDTH: master read byte address.
- REQ-009 Port MREQ, output, 1: read request to memory.
- REQ-010 Port MADDR, output, ADDR_WIDTH: memory read address.
- REQ-011 Port MACK, input, 1: memory accepted MREQ this cycle.
- REQ-012 Port RDONE, input, 1: one-cycle pulse from the downstream R stage on completion of the R handshake (RVALID && RREADY).
- REQ-013 Port AR_ERR, output, 1: the current transaction is rejected; the R stage returns SLVERR.
- REQ-014 Port BUSY, output, 1: high when any address is buffered or in flight.

Function
- REQ-015 The block SHALL contain a 2-entry FIFO of {address, err}; ARREADY SHALL equal (count < 2) and SHALL be low during reset.
- REQ-016 An address SHALL be pushed on a cycle where ARVALID && ARREADY, together with its err bit computed from ARADDR in that cycle.
- REQ-017 FSM states: IDLE, ISSUE, WAIT_R; encoded in 2 bits; any illegal encoding SHALL go to IDLE.
- REQ-018 IDLE -> ISSUE when count > 0 and the head err = 0; IDLE -> WAIT_R when count > 0 and the head err = 1.
- REQ-019 In ISSUE, MREQ SHALL be 1 and MADDR SHALL equal the head address, held stable until MACK; ISSUE -> WAIT_R on MACK.
- REQ-020 In WAIT_R, MREQ SHALL be 0 and AR_ERR SHALL equal the head err bit; WAIT_R -> IDLE on RDONE, popping the head in the same edge.
- REQ-021 AR_ERR SHALL be 0 outside WAIT_R; MREQ SHALL be 0 outside ISSUE; MADDR SHALL be 0 when MREQ is 0.
- REQ-022 At most one read SHALL be outstanding toward memory and the R stage.
- REQ-023 Latency: an address accepted at edge N with an empty FIFO and the FSM in IDLE SHALL raise MREQ in the cycle after edge N+1.
- REQ-024 A simultaneous push and pop SHALL leave count unchanged and preserve order; wrap-around of the read and write pointers SHALL be seamless.
- REQ-025 RDONE outside WAIT_R and MACK outside ISSUE SHALL be ignored.
- REQ-026 BUSY SHALL equal (count != 0) || (state != IDLE).

Reset
- REQ-027 While reset is high at an edge: state = IDLE, count = 0, pointers = 0, FIFO contents = 0.
- REQ-028 Output reset values SHALL be ARREADY = 0, MREQ = 0, MADDR = 0, AR_ERR = 0, BUSY = 0.
- REQ-029 Reset asserted mid-transaction SHALL discard all buffered and in-flight addresses without issuing any further MREQ.

Configuration
- REQ-030 With macro AR_ADDR_CHECK_EN defined, err SHALL be 1 when the low log2(DATA_WIDTH/8) bits of ARADDR are non-zero, or when ARADDR >= ADDR_LIMIT.
- REQ-031 Without AR_ADDR_CHECK_EN, err SHALL be constant 0 and the check logic SHALL be absent; every address SHALL go to memory.

Structure
- REQ-032 Package ar_pkg SHALL hold the FSM state encodings, the FIFO depth constant (2) and the response codes OKAY = 2'b00 and SLVERR = 2'b10.
- REQ-033 The FIFO SHALL be the sub-module ar_fifo (parameterised width, depth 2, push/pop/full/empty/count); the FSM and address check SHALL stay in ar_channel.

Verification
- REQ-034 Reset, then ARVALID = 1 with ARADDR = 0x10 -> ARREADY = 1, MREQ = 1 with MADDR = 0x10 two cycles after accept; MACK, then RDONE -> BUSY = 0.
- REQ-035 Hold MACK low for 5 cycles -> MREQ and MADDR stay stable; send 3 back-to-back addresses 0x0, 0x4, 0x8 -> ARREADY drops after 2 are accepted, and they are issued in order.
- REQ-036 With AR_ADDR_CHECK_EN, ARADDR = 0x6 and then 0x1000 -> no MREQ for either, AR_ERR = 1 in WAIT_R until RDONE; without the macro, both addresses are issued.
- REQ-037 Push on the same edge as the RDONE pop with count = 1 -> count stays 1 and the next MADDR is the pushed address; RDONE pulsed while in IDLE -> no state change.
- REQ-038 Assert reset during ISSUE, then release with ARVALID = 0 -> MREQ = 0, BUSY = 0 and no stale address is issued.

Source files
------------

// File: rtl/ar_pkg.sv
// Shared definitions for the AXI read-address channel slice: FSM encoding,
// FIFO sizing and the R-stage response codes.
package ar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ISSUE  = 2'b01,
        WAIT_R = 2'b10
    } ar_state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/ar_fifo.sv
// Two-entry FIFO holding {address, err} entries for ar_channel; the head is
// presented combinationally on rdata.
module ar_fifo
    import ar_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
            // NOTE: storage is cleared on reset so a stale entry can never be
            // presented as the head after reset; at depth 2 this is cheap.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ar_channel.sv
// AXI read-address channel slave: buffers up to two addresses and issues them
// one at a time to memory. Define AR_ADDR_CHECK_EN to reject misaligned or
// out-of-range addresses (answered by the R stage with SLVERR).
module ar_channel
    import ar_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  MREQ,
    output logic [ADDR_WIDTH-1:0] MADDR,
    input  logic                  MACK,
    input  logic                  RDONE,
    output logic                  AR_ERR,
    output logic                  BUSY
);

    localparam int ENTRY_W = ADDR_WIDTH + 1;

    ar_state_t               state_q;
    ar_state_t               state_d;
    logic                    in_err;
    logic                    push;
    logic                    pop;
    logic [ENTRY_W-1:0]      head;
    logic [ADDR_WIDTH-1:0]   head_addr;
    logic                    head_err;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FIFO_CNT_W-1:0]   fifo_count;

`ifdef AR_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] GRANULE_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
    localparam logic [ADDR_WIDTH-1:0] LIMIT        = ADDR_WIDTH'(ADDR_LIMIT);

    assign in_err = ((ARADDR & GRANULE_MASK) != '0) || (ARADDR >= LIMIT);
`else
    // Alignment and limit parameters only feed the optional address check.
    logic unused_cfg;
    assign unused_cfg = ^{32'(DATA_WIDTH), ADDR_LIMIT};
    assign in_err     = 1'b0;
`endif

    assign ARREADY = !reset && !fifo_full;
    assign push    = ARVALID && ARREADY;

    ar_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({ARADDR, in_err}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_addr = head[ENTRY_W-1:1];
    assign head_err  = head[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        MREQ    = 1'b0;
        MADDR   = '0;
        AR_ERR  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = head_err ? WAIT_R : ISSUE;
                end
            end
            ISSUE: begin
                MREQ  = 1'b1;
                MADDR = head_addr;
                if (MACK) begin
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                AR_ERR = head_err;
                if (RDONE) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs hold their reset values while reset is asserted.
        if (reset) begin
            MREQ   = 1'b0;
            MADDR  = '0;
            AR_ERR = 1'b0;
            pop    = 1'b0;
        end
    end

    assign BUSY = !reset && ((fifo_count != '0) || (state_q != IDLE));

endmodule

// File: tb/tb_ar_channel.sv
// Self-checking bench for ar_channel: directed scenarios followed by random
// traffic, compared each cycle against a transaction-level reference model.
module tb_ar_channel;

    localparam int AW = 32;

`ifdef AR_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ARVALID;
    logic          ARREADY;
    logic [AW-1:0] ARADDR;
    logic          MREQ;
    logic [AW-1:0] MADDR;
    logic          MACK;
    logic          RDONE;
    logic          AR_ERR;
    logic          BUSY;

    always #5 clk = ~clk;

    ar_channel dut (
        .clk     (clk),
        .reset   (reset),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .ARADDR  (ARADDR),
        .MREQ    (MREQ),
        .MADDR   (MADDR),
        .MACK    (MACK),
        .RDONE   (RDONE),
        .AR_ERR  (AR_ERR),
        .BUSY    (BUSY)
    );

    // Reference model: accepted transactions in arrival order, plus what the
    // oldest one is currently waiting for.
    typedef struct {
        logic [AW-1:0] addr;
        logic          err;
    } txn_t;

    typedef enum {PH_NEW, PH_MEM, PH_RESP} phase_t;

    txn_t   q[$];
    phase_t phase = PH_NEW;
    logic   last_push;
    int     tests = 0;
    int     fails = 0;

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic addr_err(input logic [AW-1:0] a);
        return CHECK_EN && ((a % 4 != 0) || (a >= 32'h1000));
    endfunction

    // One clock cycle: drive inputs, compare outputs with the model, then
    // advance the model across the rising edge.
    task automatic step(input logic v, input logic [AW-1:0] a, input logic mack,
                        input logic rdone, input logic rst);
        logic          e_rdy;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_err;
        logic          e_busy;
        ARVALID = v;
        ARADDR  = a;
        MACK    = mack;
        RDONE   = rdone;
        reset   = rst;
        #1;
        e_rdy  = !rst && (q.size() < 2);
        e_req  = !rst && (phase == PH_MEM);
        e_addr = e_req ? q[0].addr : '0;
        e_err  = !rst && (phase == PH_RESP) && q[0].err;
        e_busy = !rst && (q.size() != 0);
        check("ARREADY", AW'(ARREADY), AW'(e_rdy));
        check("MREQ",    AW'(MREQ),    AW'(e_req));
        check("MADDR",   MADDR,        e_addr);
        check("AR_ERR",  AW'(AR_ERR),  AW'(e_err));
        check("BUSY",    AW'(BUSY),    AW'(e_busy));
        @(posedge clk);
        last_push = v && e_rdy;
        if (rst) begin
            q.delete();
            phase = PH_NEW;
        end else begin
            case (phase)
                PH_NEW:  if (q.size() > 0) phase = q[0].err ? PH_RESP : PH_MEM;
                PH_MEM:  if (mack) phase = PH_RESP;
                PH_RESP: if (rdone) begin
                    void'(q.pop_front());
                    phase = PH_NEW;
                end
                default: phase = PH_NEW;
            endcase
            if (last_push) q.push_back('{a, addr_err(a)});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic mack, input logic rdone);
        repeat (n) step(1'b0, '0, mack, rdone, 1'b0);
    endtask

    // Hold ARVALID with a fixed address until the slave takes it.
    task automatic send(input logic [AW-1:0] a, input logic mack, input logic rdone);
        int n = 0;
        do begin
            step(1'b1, a, mack, rdone, 1'b0);
            n++;
        end while (!last_push && n < 20);
        if (!last_push) check("send_timeout", AW'(ARREADY), AW'(1'b1));
    endtask

    initial begin
        logic          v;
        logic [AW-1:0] a;
        ARVALID = 1'b0;
        ARADDR  = '0;
        MACK    = 1'b0;
        RDONE   = 1'b0;
        reset   = 1'b1;

        repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Single read: accept, issue two cycles later, MACK, RDONE.
        send(32'h10, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        idle(1, 1'b1, 1'b0);
        idle(1, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b1);

        // Back-to-back addresses with MACK held off; third waits for space.
        send(32'h0, 1'b0, 1'b0);
        send(32'h4, 1'b0, 1'b0);
        repeat (5) step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0);
        send(32'h8, 1'b1, 1'b1);
        idle(10, 1'b1, 1'b1);

        // Misaligned and out-of-range addresses, plus the last legal word.
        send(32'h6, 1'b0, 1'b0);
        idle(4, 1'b0, 1'b0);
        idle(3, 1'b1, 1'b1);
        send(32'h1000, 1'b0, 1'b0);
        idle(4, 1'b0, 1'b0);
        idle(3, 1'b1, 1'b1);
        send(32'hffc, 1'b0, 1'b0);
        idle(6, 1'b1, 1'b1);

        // Push on the same edge as the RDONE pop with one entry buffered.
        send(32'h20, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b0);
        step(1'b1, 32'h24, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b0, 1'b0);
        idle(4, 1'b1, 1'b1);
        idle(3, 1'b0, 1'b1);

        // Reset while a request is being issued.
        send(32'h30, 1'b0, 1'b0);
        send(32'h34, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(5, 1'b1, 1'b1);

        // Random traffic.
        repeat (700) begin
            v = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = AW'($urandom_range(0, 32'h3ff)) << 2;
                1:       a = AW'($urandom_range(0, 32'h1fff));
                2:       a = 32'h1000 + AW'($urandom_range(0, 8));
                default: a = 32'hff8 + AW'($urandom_range(0, 7));
            endcase
            step(v, a, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 99) == 0));
        end
        idle(8, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
